// File: rtl/oam_dma_if.sv
// Bus bundle between the core, the OAM DMA engine and memory.
// slave = the DMA engine; master = the core/memory side that drives it.
interface oam_dma_if;
  logic [15:0] I_cpu_addr;
  logic [7:0]  I_cpu_wr_data;
  logic        I_cpu_rdwr;
  logic [7:0]  I_rd_data;
  logic [15:0] O_addr;
  logic [7:0]  O_wr_data;
  logic        O_rdwr;
  logic        O_ready;
  logic        O_busy;

  modport slave (
    input  I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr, I_rd_data,
    output O_addr, O_wr_data, O_rdwr, O_ready, O_busy
  );

  modport master (
    output I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr, I_rd_data,
    input  O_addr, O_wr_data, O_rdwr, O_ready, O_busy
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: a write to 4014 halts the core and copies page {data,00..FF} to 2004.
// All state changes happen on CPU-cycle boundaries (tick 11->0); the bus is a combinational mux.
module oam_dma (
  input logic      I_clock,
  input logic      I_reset,
  oam_dma_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PEND  = 3'd1;
  localparam logic [2:0] ST_HALT  = 3'd2;
  localparam logic [2:0] ST_ALIGN = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;
  localparam logic [2:0] ST_WRITE = 3'd5;

  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_DATA = 16'h2004;

  logic [3:0] tick;
  logic       parity;
  logic       boundary;
  logic [2:0] state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data;
  logic       ready;

  assign boundary = (tick == 4'd11);

  // Parity 0 marks a GET cycle, 1 a PUT cycle; it names the CPU cycle now in progress.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      tick   <= 4'd0;
      parity <= 1'b0;
    end else if (boundary) begin
      tick   <= 4'd0;
      parity <= ~parity;
    end else begin
      tick   <= tick + 4'd1;
    end
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state <= ST_IDLE;
      page  <= 8'h00;
      idx   <= 8'h00;
      data  <= 8'h00;
      ready <= 1'b1;
    end else if (boundary) begin
      case (state)
        ST_IDLE: begin
          if (!bus.I_cpu_rdwr && bus.I_cpu_addr == DMA_REG) begin
            page  <= bus.I_cpu_wr_data;
            idx   <= 8'h00;
            state <= ST_PEND;
          end
        end
        ST_PEND: begin
          // The core can only be stopped on one of its read cycles.
          if (bus.I_cpu_rdwr) begin
            state <= ST_HALT;
            ready <= 1'b0;
          end
        end
        ST_HALT:  state <= parity ? ST_READ : ST_ALIGN;
        ST_ALIGN: state <= ST_READ;
        ST_READ: begin
          data  <= bus.I_rd_data;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          idx <= idx + 8'd1;
          if (idx == 8'hFF) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end else begin
            state <= ST_READ;
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    bus.O_addr    = bus.I_cpu_addr;
    bus.O_wr_data = bus.I_cpu_wr_data;
    bus.O_rdwr    = bus.I_cpu_rdwr;
    case (state)
      ST_HALT, ST_ALIGN: bus.O_rdwr = 1'b1;
      ST_READ: begin
        bus.O_addr = {page, idx};
        bus.O_rdwr = 1'b1;
      end
      ST_WRITE: begin
        bus.O_addr    = OAM_DATA;
        bus.O_wr_data = data;
        bus.O_rdwr    = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.O_ready = ready;
  assign bus.O_busy  = (state != ST_IDLE);

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 I_clock  in  1  system clock (12 ticks per CPU cycle).
REQ-002 I_reset  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 I_cpu_addr  in  16  core address output.
REQ-004 I_cpu_wr_data  in  8  core write data.
REQ-005 I_cpu_rdwr  in  1  core direction; 1=read, 0=write.
REQ-006 I_rd_data  in  8  memory read data.
REQ-007 O_addr  out  16  arbitrated bus address.
REQ-008 O_wr_data  out  8  arbitrated write data.
REQ-009 O_rdwr  out  1  arbitrated direction; 1=read.
REQ-010 O_ready  out  1  to core I_ready; 0 halts core.
REQ-011 O_busy  out  1  1 while state is not IDLE.

Function
REQ-012 Free-running tick counter 0..11, wraps 11->0; "boundary" = clock edge where tick goes 11->0.
REQ-013 Parity bit toggles at every boundary; parity 0 = GET cycle, 1 = PUT cycle.
REQ-014 Trigger: at a boundary with I_cpu_rdwr=0 and I_cpu_addr=16'h4014, latch page=I_cpu_wr_data, idx=0, state IDLE->PEND.
REQ-015 States: IDLE, PEND, HALT, ALIGN, READ, WRITE; all transitions occur only at boundaries.
REQ-016 PEND: at a boundary with I_cpu_rdwr=1 -> HALT and O_ready=0; with I_cpu_rdwr=0 remain PEND.
REQ-017 HALT (one cycle): next state READ if next cycle is GET, else ALIGN.
REQ-018 ALIGN (one cycle): -> READ.
REQ-019 READ: O_addr={page,idx}, O_rdwr=1; latch I_rd_data into data register on the clock with tick=11; -> WRITE.
REQ-020 WRITE: O_addr=16'h2004, O_rdwr=0, O_wr_data=data register; at boundary idx increments mod 256; idx was 255 -> IDLE with O_ready=1, else -> READ.
REQ-021 HALT/ALIGN: bus passes through core address with O_rdwr=1 (dummy read).
REQ-022 IDLE/PEND: O_addr=I_cpu_addr, O_wr_data=I_cpu_wr_data, O_rdwr=I_cpu_rdwr, combinational.
REQ-023 O_ready registered; changes only at boundaries; low from entry to HALT through end of final WRITE.
REQ-024 Total halt length: 513 CPU cycles (no ALIGN) or 514 (with ALIGN).
REQ-025 Writes to 16'h4014 while state is not IDLE are ignored.
REQ-026 Page 8'hFF is legal; read addresses 16'hFF00..16'hFFFF; no wrap into page+1.

Reset
REQ-027 Reset asserted: state=IDLE, tick=0, parity=0, idx=0, page=0, data=0, O_ready=1, O_busy=0, bus in passthrough.
REQ-028 Reset mid-transfer aborts immediately; no further bus cycles; O_ready=1 asynchronously.
REQ-029 After reset release, tick counter starts at 0 in lockstep with core divider.

Verification
REQ-030 Write 8'h02 to 16'h4014 at a GET boundary, CPU reads next -> O_ready low 513 cycles; reads 16'h0200..16'h02FF each followed by write to 16'h2004 with matching byte.
REQ-031 Same trigger landing so that the cycle after HALT is PUT -> exactly one ALIGN cycle; O_ready low 514 cycles.
REQ-032 CPU writes on two cycles after trigger -> stays PEND, O_ready=1, passthrough, until first CPU read boundary.
REQ-033 Memory pattern byte=idx^8'hA5, page 8'hFF -> 256 writes to 16'h2004 of idx^8'hA5; last read address 16'hFFFF.
REQ-034 Reset asserted during READ of idx 8'h40 -> O_ready=1, O_busy=0 immediately; new trigger after release restarts at idx 0.
REQ-035 Write 16'h4014 while halted (forced stimulus) -> ignored; transfer completes unchanged.
